// File: rtl/arb_pkg.sv
// arb_pkg: shared types and reset constants for the data memory arbiter.
// Holds the owner encoding, the request bundle and the default widths.
package arb_pkg;

  localparam int ARB_DATA_BITS = 12;
  localparam int ARB_ADDR_MAX  = 30;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } arb_owner_t;

  typedef struct packed {
    logic                    we;
    logic                    lock;
    logic [ARB_ADDR_MAX-1:0] addr;
    logic [3:0]              byteena;
    logic [31:0]             wdata;
  } mem_req_t;

  localparam arb_owner_t  RST_OWNER  = OWN_NONE;
  localparam logic [31:0] RST_RDATA  = '0;
  localparam logic        RST_RVALID = 1'b0;
  localparam logic        RST_PRIO_B = 1'b0;

  // Bundle is all-zero unless granted, so bundles can be OR-merged.
  function automatic mem_req_t mk_req(
    input logic                    en,
    input logic                    we,
    input logic                    lock,
    input logic [ARB_ADDR_MAX-1:0] addr,
    input logic [3:0]              be,
    input logic [31:0]             wd
  );
    mem_req_t r;
    r = '0;
    if (en) begin
      r.we      = we;
      r.lock    = lock;
      r.addr    = addr;
      r.byteena = be;
      r.wdata   = wd;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_resp_reg.sv
// arb_resp_reg: one-cycle registered read response for one port.
// Ports: clock, reset_n, capture, mem_q in; rvalid, rdata out.
module arb_resp_reg
  import arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        capture,
  input  logic [31:0] mem_q,
  output logic        rvalid,
  output logic [31:0] rdata
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= RST_RVALID;
      rdata  <= RST_RDATA;
    end else begin
      rvalid <= capture;
      if (capture) rdata <= mem_q;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one data memory between ports A and B,
// with bounded locking. ARB_ROUND_ROBIN_EN selects round-robin over
// fixed A priority. Ports: a_*/b_* requests, *_gnt, *_rvalid/*_rdata,
// mem_address/byteena/data/wren out, mem_q in.
module data_memory_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_BITS = ARB_DATA_BITS,
  parameter int LOCK_MAX  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic                 a_lock,
  input  logic [DATA_BITS-3:0] a_addr,
  input  logic [3:0]           a_byteena,
  input  logic [31:0]          a_wdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic                 b_lock,
  input  logic [DATA_BITS-3:0] b_addr,
  input  logic [3:0]           b_byteena,
  input  logic [31:0]          b_wdata,
  output logic                 a_gnt,
  output logic                 b_gnt,
  output logic                 a_rvalid,
  output logic                 b_rvalid,
  output logic [31:0]          a_rdata,
  output logic [31:0]          b_rdata,
  output logic [DATA_BITS-3:0] mem_address,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_data,
  output logic                 mem_wren,
  input  logic [31:0]          mem_q
);

  localparam int AW = DATA_BITS - 2;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_MAX);

  arb_owner_t    owner;
  logic [CW-1:0] cnt;
  logic          bar_a;
  logic          bar_b;
  logic          a_ok;
  logic          b_ok;
  logic          a_win;
  logic          b_win;
  mem_req_t      a_pkt;
  mem_req_t      b_pkt;
  mem_req_t      sel;
  logic          unused_addr;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_b;
`endif

  assign a_ok = a_req & ~bar_a;
  assign b_ok = b_req & ~bar_b;

  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    unique case (1'b1)
      (owner == OWN_A): a_win = a_req;
      (owner == OWN_B): b_win = b_req;
      default: begin
`ifdef ARB_ROUND_ROBIN_EN
        a_win = a_ok & (~b_ok | ~prio_b);
        b_win = b_ok & (~a_ok | prio_b);
`else
        a_win = a_ok;
        b_win = b_ok & ~a_ok;
`endif
      end
    endcase
  end

  // Gating by reset_n also kills a write issued as reset asserts.
  assign a_gnt = a_win & reset_n;
  assign b_gnt = b_win & reset_n;

  assign a_pkt = mk_req(a_gnt, a_we, a_lock,
                        ARB_ADDR_MAX'(a_addr),
                        a_byteena, a_wdata);
  assign b_pkt = mk_req(b_gnt, b_we, b_lock,
                        ARB_ADDR_MAX'(b_addr),
                        b_byteena, b_wdata);
  assign sel   = a_pkt | b_pkt;

  assign mem_address = sel.addr[AW-1:0];
  assign mem_byteena = sel.byteena;
  assign mem_data    = sel.wdata;
  assign mem_wren    = sel.we;
  assign unused_addr = ^sel.addr[ARB_ADDR_MAX-1:AW];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner <= RST_OWNER;
      cnt   <= '0;
      bar_a <= 1'b0;
      bar_b <= 1'b0;
    end else begin
      bar_a <= 1'b0;
      bar_b <= 1'b0;
      unique case (1'b1)
        (owner == OWN_A): begin
          if (!a_lock) begin
            owner <= OWN_NONE;
          end else if (cnt == CNT_LAST) begin
            owner <= OWN_NONE;
            bar_a <= 1'b1;
            cnt   <= CNT_MAX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        (owner == OWN_B): begin
          if (!b_lock) begin
            owner <= OWN_NONE;
          end else if (cnt == CNT_LAST) begin
            owner <= OWN_NONE;
            bar_b <= 1'b1;
            cnt   <= CNT_MAX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (sel.lock) begin
            owner <= a_gnt ? OWN_A : OWN_B;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_b <= RST_PRIO_B;
    end else if (a_gnt | b_gnt) begin
      prio_b <= a_gnt;
    end
  end
`endif

  arb_resp_reg u_resp_a (
    .clock   (clock),
    .reset_n (reset_n),
    .capture (a_gnt & ~a_we),
    .mem_q   (mem_q),
    .rvalid  (a_rvalid),
    .rdata   (a_rdata)
  );

  arb_resp_reg u_resp_b (
    .clock   (clock),
    .reset_n (reset_n),
    .capture (b_gnt & ~b_we),
    .mem_q   (mem_q),
    .rvalid  (b_rvalid),
    .rdata   (b_rdata)
  );

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed and random checks of the arbiter
// against a port-level behavioural model and a modelled memory.
module tb_data_memory_arbiter;

  localparam int DB = 12;
  localparam int AW = DB - 2;
  localparam int LM = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req, a_we, a_lock;
  logic [AW-1:0] a_addr;
  logic [3:0]    a_byteena;
  logic [31:0]   a_wdata;
  logic          b_req, b_we, b_lock;
  logic [AW-1:0] b_addr;
  logic [3:0]    b_byteena;
  logic [31:0]   b_wdata;
  logic          a_gnt, b_gnt;
  logic          a_rvalid, b_rvalid;
  logic [31:0]   a_rdata, b_rdata;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteena;
  logic [31:0]   mem_data;
  logic          mem_wren;
  logic [31:0]   mem_q;

  always #5 clock = ~clock;

  data_memory_arbiter #(.DATA_BITS(DB), .LOCK_MAX(LM)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_lock      (a_lock),
    .a_addr      (a_addr),
    .a_byteena   (a_byteena),
    .a_wdata     (a_wdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_lock      (b_lock),
    .b_addr      (b_addr),
    .b_byteena   (b_byteena),
    .b_wdata     (b_wdata),
    .a_gnt       (a_gnt),
    .b_gnt       (b_gnt),
    .a_rvalid    (a_rvalid),
    .b_rvalid    (b_rvalid),
    .a_rdata     (a_rdata),
    .b_rdata     (b_rdata),
    .mem_address (mem_address),
    .mem_byteena (mem_byteena),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  // Memory attached to the DUT pins, with a backdoor for preloading.
  logic [31:0] ram [0:31];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  assign mem_q = ram[mem_address[4:0]];

  always @(posedge clock) begin
    if (mem_wren) begin
      for (int i = 0; i < 4; i++)
        if (mem_byteena[i])
          ram[mem_address[4:0]][8*i +: 8] <= mem_data[8*i +: 8];
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end
  end

  // Reference model: ports numbered 1 (A) and 2 (B), 0 = nobody.
  logic [31:0] mm [0:31];
  int          own;
  int          held;
  int          bar;
  int          last;
  int          w;
  bit          ev [1:2];
  logic [31:0] ed [1:2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    own = 0;
    held = 0;
    bar = 0;
    last = 2;
    ev[1] = 0;
    ev[2] = 0;
    ed[1] = '0;
    ed[2] = '0;
  endfunction

  function automatic void fields(input int p,
                                 output logic rq,
                                 output logic we,
                                 output logic lk,
                                 output logic [AW-1:0] ad,
                                 output logic [3:0] be,
                                 output logic [31:0] wd);
    rq = 0; we = 0; lk = 0;
    ad = '0; be = '0; wd = '0;
    if (p == 1) begin
      rq = a_req; we = a_we; lk = a_lock;
      ad = a_addr; be = a_byteena; wd = a_wdata;
    end else if (p == 2) begin
      rq = b_req; we = b_we; lk = b_lock;
      ad = b_addr; be = b_byteena; wd = b_wdata;
    end
  endfunction

  function automatic int pick();
    bit r [1:2];
    if (!reset_n) return 0;
    r[1] = a_req;
    r[2] = b_req;
    if (own != 0) return r[own] ? own : 0;
    if (bar != 0) r[bar] = 0;
    if (r[1] && r[2]) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last == 1) ? 2 : 1;
`else
      return 1;
`endif
    end
    if (r[1]) return 1;
    if (r[2]) return 2;
    return 0;
  endfunction

  function automatic void commit();
    logic rq, we, lk;
    logic [AW-1:0] ad;
    logic [3:0] be;
    logic [31:0] wd;
    int nbar;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ev[1] = 0;
    ev[2] = 0;
    if (w != 0) begin
      fields(w, rq, we, lk, ad, be, wd);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mm[int'(ad)][8*i +: 8] = wd[8*i +: 8];
      end else begin
        ev[w] = 1;
        ed[w] = mm[int'(ad)];
      end
    end
    nbar = 0;
    if (own == 0) begin
      fields(w, rq, we, lk, ad, be, wd);
      if (w != 0 && lk) begin
        own = w;
        held = 0;
      end
    end else begin
      fields(own, rq, we, lk, ad, be, wd);
      if (!lk) begin
        own = 0;
      end else begin
        held++;
        if (held >= LM) begin
          nbar = own;
          own = 0;
        end
      end
    end
    bar = nbar;
    if (w != 0) last = w;
  endfunction

  // Combinational phase: grants and memory pins for this cycle.
  task automatic settle();
    logic rq, we, lk;
    logic [AW-1:0] ad;
    logic [3:0] be;
    logic [31:0] wd;
    #2;
    w = pick();
    fields(w, rq, we, lk, ad, be, wd);
    chk("a_gnt", 32'(a_gnt), 32'(w == 1));
    chk("b_gnt", 32'(b_gnt), 32'(w == 2));
    chk("mem_wren", 32'(mem_wren), 32'(we));
    chk("mem_address", 32'(mem_address), 32'(ad));
    chk("mem_byteena", 32'(mem_byteena), 32'(be));
    chk("mem_data", mem_data, wd);
  endtask

  // Registered phase: responses after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    commit();
    chk("a_rvalid", 32'(a_rvalid), 32'(ev[1]));
    chk("b_rvalid", 32'(b_rvalid), 32'(ev[2]));
    chk("a_rdata", a_rdata, ed[1]);
    chk("b_rdata", b_rdata, ed[2]);
  endtask

  task automatic set_a(input logic rq, input logic we,
                       input logic lk, input int ad,
                       input logic [3:0] be,
                       input logic [31:0] wd);
    a_req = rq; a_we = we; a_lock = lk;
    a_addr = AW'(ad); a_byteena = be; a_wdata = wd;
  endtask

  task automatic set_b(input logic rq, input logic we,
                       input logic lk, input int ad,
                       input logic [3:0] be,
                       input logic [31:0] wd);
    b_req = rq; b_we = we; b_lock = lk;
    b_addr = AW'(ad); b_byteena = be; b_wdata = wd;
  endtask

  task automatic rnd_a();
    set_a($urandom_range(0, 3) != 0, 1'($urandom),
          1'($urandom), $urandom_range(0, 31),
          4'($urandom), $urandom);
  endtask

  task automatic rnd_b();
    set_b($urandom_range(0, 3) != 0, 1'($urandom),
          1'($urandom), $urandom_range(0, 31),
          4'($urandom), $urandom);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    w = 0;
    set_a(1, 1, 0, 3, 4'hf, 32'h1);
    set_b(1, 0, 1, 4, 4'hf, 32'h2);
    #1;
    for (int i = 0; i < 32; i++) begin
      d = (i == 16) ? 32'hDEADBEEF :
          (i == 5)  ? 32'h11223344 : $urandom;
      bd_we = 1'b1;
      bd_addr = 5'(i);
      bd_data = d;
      mm[i] = d;
      cyc();
    end
    bd_we = 1'b0;
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    reset_n = 1'b1;
    set_a(0, 0, 0, 0, 4'h0, 32'h0);
    set_b(0, 0, 0, 0, 4'h0, 32'h0);
    cyc();

    // Single read of a preloaded word.
    set_a(1, 0, 0, 16, 4'hf, 32'h0);
    settle();
    chk("rd_gnt", 32'(a_gnt), 32'd1);
    tick();
    chk("rd_rvalid", 32'(a_rvalid), 32'd1);
    chk("rd_rdata", a_rdata, 32'hDEADBEEF);
    set_a(0, 0, 0, 0, 4'h0, 32'h0);
    cyc();
    chk("rd_rvalid_drop", 32'(a_rvalid), 32'd0);

    // B partial write, then A read of the same word.
    set_b(1, 1, 0, 5, 4'b0010, 32'h0000AB00);
    cyc();
    set_b(0, 0, 0, 0, 4'h0, 32'h0);
    set_a(1, 0, 0, 5, 4'hf, 32'h0);
    cyc();
    chk("pw_rdata", a_rdata, 32'h1122AB44);
    set_a(0, 0, 0, 0, 4'h0, 32'h0);
    cyc();

    // B holds a lock for three accesses while A waits.
    set_b(1, 0, 1, 2, 4'hf, 32'h0);
    cyc();
    set_a(1, 0, 0, 3, 4'hf, 32'h0);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("lk_a_blocked", 32'(a_gnt), 32'd0);
      tick();
    end
    set_b(0, 0, 0, 0, 4'h0, 32'h0);
    settle();
    chk("lk_a_drop_cyc", 32'(a_gnt), 32'd0);
    tick();
    settle();
    chk("lk_a_after", 32'(a_gnt), 32'd1);
    tick();
    set_a(0, 0, 0, 0, 4'h0, 32'h0);
    cyc();

    // B never lets go: forced release after LM owned cycles.
    set_b(1, 0, 1, 6, 4'hf, 32'h0);
    cyc();
    set_a(1, 0, 0, 7, 4'hf, 32'h0);
    for (int i = 0; i < LM; i++) begin
      settle();
      chk("to_b_own", 32'(b_gnt), 32'd1);
      tick();
    end
    settle();
    chk("to_a_next", 32'(a_gnt), 32'd1);
    chk("to_b_barred", 32'(b_gnt), 32'd0);
    tick();
    set_a(0, 0, 0, 0, 4'h0, 32'h0);
    set_b(1, 0, 0, 6, 4'hf, 32'h0);
    settle();
    chk("to_b_back", 32'(b_gnt), 32'd1);
    tick();
    set_b(0, 0, 0, 0, 4'h0, 32'h0);

    // Contention straight out of reset.
    do_reset(2);
    set_a(1, 0, 0, 8, 4'hf, 32'h0);
    set_b(1, 0, 0, 9, 4'hf, 32'h0);
    for (int i = 0; i < 4; i++) begin
      logic ea;
`ifdef ARB_ROUND_ROBIN_EN
      ea = (i % 2) == 0;
`else
      ea = 1'b1;
`endif
      settle();
      chk("ct_a_gnt", 32'(a_gnt), 32'(ea));
      chk("ct_b_gnt", 32'(b_gnt), 32'(!ea));
      tick();
    end
    set_a(0, 0, 0, 0, 4'h0, 32'h0);
    set_b(0, 0, 0, 0, 4'h0, 32'h0);
    cyc();

    // Reset lands while B owns the bus with a read granted.
    set_b(1, 0, 1, 10, 4'hf, 32'h0);
    cyc();
    set_a(1, 1, 0, 7, 4'hf, 32'hCAFEF00D);
    settle();
    chk("rl_b_gnt", 32'(b_gnt), 32'd1);
    #1;
    reset_n = 1'b0;
    model_reset();
    w = 0;
    #1;
    chk("rl_b_gnt_rst", 32'(b_gnt), 32'd0);
    chk("rl_a_gnt_rst", 32'(a_gnt), 32'd0);
    chk("rl_wren_rst", 32'(mem_wren), 32'd0);
    chk("rl_b_rvalid", 32'(b_rvalid), 32'd0);
    tick();
    reset_n = 1'b1;
    set_b(1, 0, 1, 10, 4'hf, 32'h0);
    set_a(1, 0, 0, 7, 4'hf, 32'h0);
    settle();
    chk("rl_a_first", 32'(a_gnt), 32'd1);
    tick();
    chk("rl_no_write", a_rdata, mm[7]);
    set_b(0, 0, 0, 0, 4'h0, 32'h0);

    // Random traffic; requests are held until granted.
    rnd_a();
    rnd_b();
    for (int n = 0; n < 600; n++) begin
      cyc();
      if (w == 1 || !a_req) rnd_a();
      if (w == 2 || !b_req) rnd_b();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-port data memory between the core load/store unit (port A) and the program loader/debug port (port B). Issues at most one memory access per cycle and drives the memory's address, byte-enable, write-data and write-enable pins. Captures the combinational read data into a registered one-cycle response. Supports bounded bus locking for multi-word atomic sequences.

## Interface
- `DATA_BITS`, default from `config.sv`: memory byte-address width; word address is `DATA_BITS-2` bits.
- `LOCK_MAX`, default 16: maximum consecutive cycles one port may hold a lock.
- `clock` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `a_req`, `b_req` in 1: access request, held until granted.
- `a_we`, `b_we` in 1: 1 = write, 0 = read.
- `a_lock`, `b_lock` in 1: request to keep ownership after this access.
- `a_addr`, `b_addr` in `DATA_BITS-2`: word address.
- `a_byteena`, `b_byteena` in 4: byte lanes.
- `a_wdata`, `b_wdata` in 32: write data.
- `a_gnt`, `b_gnt` out 1: combinational; the access is performed this cycle.
- `a_rvalid`, `b_rvalid` out 1: registered; read data is valid this cycle.
- `a_rdata`, `b_rdata` out 32: registered read data.
- `mem_address` out `DATA_BITS-2`, `mem_byteena` out 4, `mem_data` out 32, `mem_wren` out 1: data memory port.
- `mem_q` in 32: combinational memory read data.

## Operation
- FSM states are OWN_NONE, OWN_A and OWN_B (lock owner).
  - OWN_NONE: arbitrate between pending requests.
  - OWN_A / OWN_B: only the owner may be granted. The other port gets `gnt=0` even if it is requesting.
- Transitions:
  - From OWN_NONE: a granted access with its port's lock=1 moves to OWN_x.
  - From OWN_x: a cycle where the owner presents req=1 with lock=0 moves to OWN_NONE after that access. So does a cycle where the owner presents req=0 with lock=0.
  - From OWN_x: a lock counter reaching `LOCK_MAX` forces OWN_NONE, and the owner is barred from arbitration for one cycle.
- Lock counter:
  - Counts granted or idle cycles in OWN_x.
  - Cleared on entering OWN_x.
  - Saturates at `LOCK_MAX`; width is `$clog2(LOCK_MAX+1)`.
- Mux:
  - `mem_*` follow the granted port.
  - With no grant: `mem_wren=0`, `mem_byteena=0`, `mem_address=0`, `mem_data=0`.
- Writes:
  - `mem_wren=gnt&we`; memory commits at the same edge.
  - No rvalid is produced for a write.
- Reads:
  - At the edge ending a granted read, `x_rdata<=mem_q` and `x_rvalid<=1`.
  - Otherwise `x_rvalid<=0` and `x_rdata` holds its value.
- Both ports use the same address:
  - A read in cycle N+1 observes a write granted in cycle N.
  - Ports never both access in one cycle, so there is no same-cycle hazard.

## Timing
- Grant latency is 0 cycles (same cycle as req) when the port wins. Read latency is 1 cycle (rvalid on the next cycle).
- Throughput: one access per cycle, sustained back-to-back for a single port.
- Reset values:
  - `a_rvalid`, `b_rvalid` = 0; `a_rdata`, `b_rdata` = 0.
  - FSM = OWN_NONE; lock counter = 0; round-robin pointer = A.
  - Gnts and `mem_wren` = 0 during reset.
- Reset asserted mid-lock or mid-read:
  - Ownership is dropped and pending rvalids are discarded.
  - A write granted in the same cycle as reset assertion is not performed (`mem_wren` is gated by `reset_n`).
- Simultaneous `a_req` and `b_req` in OWN_NONE: resolved per Configuration.
- A lock request from a non-granted port is ignored.

## Configuration
- `ARB_ROUND_ROBIN_EN`
  - Defined: on simultaneous requests in OWN_NONE, the port not granted most recently wins. The pointer updates on every grant.
  - Undefined: fixed priority, port A (core) always wins. The pointer register is not instantiated.

## Structure
- Shared package `arb_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} arb_owner_t`.
  - `typedef struct packed {we, lock, addr, byteena, wdata} mem_req_t`.
  - Reset constants.
- One natural sub-module, `arb_resp_reg`: per-port registered rvalid/rdata capture, instantiated twice.

## Test plan
- A single read:
  - Preload mem[0x10]=0xDEADBEEF; `a_req=1`, `we=0`, `addr=0x10` in cycle 0.
  - Required: `a_gnt=1` in cycle 0; `a_rvalid=1` and `a_rdata=0xDEADBEEF` in cycle 1.
- B partial write, then A read:
  - B writes `byteena=4'b0010`, `wdata=0x0000AB00` to a word holding 0x11223344, then A reads it.
  - Required: A sees 0x1122AB44.
- Contention, both ports requesting every cycle for 4 cycles:
  - Without the macro: grants A,A,A,A.
  - With `ARB_ROUND_ROBIN_EN`: grants A,B,A,B.
- Lock, B holding `b_lock=1` for 3 accesses while A requests:
  - Required: `a_gnt=0` for those 3 cycles; A is granted on the cycle after B drops lock.
- Lock timeout, B holding lock indefinitely with `LOCK_MAX=4`:
  - Required: forced release after 4 cycles; A granted next; B barred one cycle.
- Reset mid-lock:
  - Deassert `reset_n` while in OWN_B with a read granted.
  - Required: `b_rvalid=0`, FSM returns to OWN_NONE, `mem_wren=0`; after release, A is granted immediately.
